seq_div_16x8: RTL

SEQ_DIV_16X8 -- requirements
Module: seq_div_16x8

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 22 ++
 rtl/seq_div_16x8.sv | 139 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared FSM state type and default width for the sequential divider
package div_pkg;

  localparam int BIT_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift in a dividend bit, trial-subtract, restore
module div_step
  import div_pkg::*;
#(
  parameter int BIT = BIT_DEFAULT
) (
  input  logic [BIT-1:0] rem_i,
  input  logic           bit_i,
  input  logic [BIT-1:0] divisor_i,
  output logic [BIT-1:0] rem_o,
  output logic           q_bit_o
);

  logic [BIT:0] shifted;

  // The partial remainder stays below the divisor, so the shifted value fits in BIT+1 bits
  // and the difference (when taken) fits back into BIT bits.
  assign shifted = {rem_i, bit_i};
  assign q_bit_o = (shifted >= {1'b0, divisor_i});
  assign rem_o   = q_bit_o ? (shifted[BIT-1:0] - divisor_i) : shifted[BIT-1:0];

endmodule

// File: rtl/seq_div_16x8.sv
// rtl/seq_div_16x8.sv - sequential 2*BIT / BIT unsigned restoring divider with valid/ready handshakes
module seq_div_16x8
  import div_pkg::*;
#(
  parameter int BIT = BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*BIT-1:0] dividend,
  input  logic [BIT-1:0]   divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIT-1:0]   quotient,
  output logic [BIT-1:0]   remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = (BIT > 2) ? $clog2(BIT) : 1;

  div_state_e     state_q, state_d;
  logic [BIT-1:0] rem_q, rem_d;
  logic [BIT-1:0] sh_q, sh_d;
  logic [BIT-1:0] dsr_q, dsr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BIT-1:0] quot_q, quot_d;
  logic [BIT-1:0] remo_q, remo_d;
  logic           dz_q, dz_d;
  logic           ov_q, ov_d;
  logic           in_ready_q;
  logic           out_valid_q;

  logic [BIT-1:0] step_rem;
  logic           step_q;
  logic           accept;

  div_step #(.BIT(BIT)) u_step (
    .rem_i     (rem_q),
    .bit_i     (sh_q[BIT-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  // in_ready_q is only set once the state is IDLE, so it doubles as the IDLE flag.
  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dsr_d = divisor;
          if (divisor == '0) begin
            state_d = ST_DONE;
            quot_d  = '1;
            remo_d  = dividend[BIT-1:0];
            dz_d    = 1'b1;
            ov_d    = 1'b0;
          end else if (dividend[2*BIT-1:BIT] >= divisor) begin
            state_d = ST_DONE;
            quot_d  = '1;
            remo_d  = dividend[BIT-1:0];
            dz_d    = 1'b0;
            ov_d    = 1'b1;
          end else begin
            state_d = ST_CALC;
            rem_d   = dividend[2*BIT-1:BIT];
            sh_d    = dividend[BIT-1:0];
            cnt_d   = CW'(BIT - 1);
          end
        end
      end
      ST_CALC: begin
        // Dividend bits leave sh_q at the top while quotient bits enter at the bottom.
        rem_d = step_rem;
        sh_d  = {sh_q[BIT-2:0], step_q};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          quot_d  = {sh_q[BIT-2:0], step_q};
          remo_d  = step_rem;
          dz_d    = 1'b0;
          ov_d    = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      sh_q        <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      quot_q      <= '0;
      remo_q      <= '0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      sh_q        <= sh_d;
      dsr_q       <= dsr_d;
      cnt_q       <= cnt_d;
      quot_q      <= quot_d;
      remo_q      <= remo_d;
      dz_q        <= dz_d;
      ov_q        <= ov_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign div_zero  = dz_q;
  assign overflow  = ov_q;

endmodule
